alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
// Issue and writeback stage wrapped around the combinational ALU. Accepts one decoded
// ALU instruction per cycle over a valid/ready handshake and owns the 32x32 integer
// register file. Drives ALU operands and ALUop from an EX pipeline register, then
// captures the ALU result and status and writes the result back to the register file.
// PARAMETERS
// XLEN      32  datapath width; must match the ALU width
// NREGS     32  architectural register count; index width is $clog2(NREGS)
// PORTS
// clk          in   1     rising-edge clock
// reset        in   1     synchronous, active-high reset
// in_valid     in   1     decoded instruction present
// in_ready     out  1     stage can accept: ~hold & ~trap
// in_op        in   4     ALUop: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 SL, 7 SR
// in_rs1       in   5     source register for Ain
// in_rs2       in   5     source register for Bin (used when in_use_imm=0)
// in_rd        in   5     destination register
// in_imm       in   XLEN  immediate for Bin (used when in_use_imm=1)
// in_use_imm   in   1     1: Bin=in_imm; 0: Bin=rf[rs2]
// hold         in   1     freeze: EX register and writeback are held
// alu_a        out  XLEN  to ALU Ain (EX register)
// alu_b        out  XLEN  to ALU Bin (EX register)
// alu_op       out  4     to ALU ALUop (EX register)
// alu_out      in   XLEN  ALU result
// alu_status   in   3     ALU status {N,V,Z}
// wb_valid     out  1     1-cycle pulse: a result was retired this cycle
// wb_rd        out  5     retired destination register
// wb_data      out  XLEN  retired result
// flags        out  3     {N,V,Z} of the last retired instruction (registered)
// illegal_op   out  1     1-cycle pulse: an op with in_op[3]=1 was retired as a NOP
// trap         out  1     sticky overflow trap; only when ALU_OVF_TRAP_EN is defined, else tied to 0
// BEHAVIOUR
// - Reset (sync): RF all 0; ex_valid=0; alu_a/alu_b/alu_op=0; wb_*=0; flags=0;
//   illegal_op=0; trap=0. An instruction in flight at reset is dropped and makes no RF write.
// - Accept: in_valid & in_ready at edge T loads the EX register (op, rd, A, B) and sets ex_valid.
// - Operand read at T: rf[rs] with x0 reads as 0. When rs!=0 and rs equals the rd retiring
//   this cycle, the operand is forwarded from alu_out, so back-to-back dependents never stall.
// - Execute/retire: the ALU is combinational on the EX register. At edge T+1, if ex_valid & ~hold:
//   wb_valid=1, wb_rd=ex_rd, wb_data=alu_out, flags=alu_status, and rf[ex_rd]=alu_out.
//   Latency is 2 edges from accept to wb_valid and the RF update. Throughput is 1 per cycle.
// - Retire with no new accept clears ex_valid. Accept and retire in the same cycle are both
//   allowed.
// - rd=0: wb_valid still pulses. The RF is unchanged and x0 stays 0.
// - in_op[3]=1 (ops 8..15): accepted. At retire: wb_valid=0, no RF write, flags unchanged,
//   illegal_op pulses. The ALU is driven with alu_op=0 for that cycle.
// - hold=1: in_ready=0. EX register, wb_* and flags are frozen and no RF write occurs.
//   wb_valid=0 while held.
// - NOT ignores B. SL/SR shift amount is alu_b[4:0], with interpretation owned by the ALU.
// CONFIGURATION
// - ALU_OVF_TRAP_EN defined: on retire of ADD or SUB with alu_status[1]=1 the RF write is
//   suppressed and wb_valid=0. flags still update. trap sets and stays set until reset.
//   in_ready=0 while trap=1. The instruction in EX at that point is the last one retired.
// - Not defined: overflow is reported in flags[1] only. All retires write. trap=0.
// STRUCTURE
// - alu_pkg:
//   - alu_op_e enum (ADD..SR)
//   - status bit indices ST_Z=0, ST_V=1, ST_N=2
//   - XLEN
//   - REG_IDX_W
// - Sub-module regfile_2r1w: 2 async read ports and 1 sync write port, x0 hardwired to 0,
//   sync reset clears all entries. Forwarding muxes stay in alu_issue_stage.
// TESTING
// 1. Reset, then ADD x1 = x0 + imm 5 -> wb_valid 2 edges later, wb_rd=1, wb_data=5,
//    flags=000, rf[1]=5.
// 2. Back-to-back dependency: x1=5 then SUB x2 = x1 - imm 5 the next cycle ->
//    forwarded A=5, wb_data=0, flags=001.
// 3. Write to x0: ADD rd=0, imm 7 -> wb_valid=1, then read x0 as operand gives A=0.
// 4. hold asserted for 3 cycles with one instruction in EX -> in_ready=0 and no wb_valid;
//    retires on the first edge after hold drops.
// 5. ADD 0x7FFFFFFF + 1 -> flags=110. Trap build: trap=1, in_ready=0, rd unchanged.
//    Non-trap build: rd=0x80000000.
// 6. Op 4'b1010 accepted -> illegal_op pulse, wb_valid=0; reset mid-flight gives no RF
//    write and all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU issue/writeback slice.
// Optional overflow trap is enabled with ALU_OVF_TRAP_EN.
package alu_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = $clog2(NREGS);

  localparam int ST_Z = 0;
  localparam int ST_V = 1;
  localparam int ST_N = 2;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOT = 3'd4,
    OP_XOR = 3'd5,
    OP_SL  = 3'd6,
    OP_SR  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decoded-instruction handshake into the ALU issue stage.
// Master drives the instruction, slave returns in_ready.
interface alu_issue_stage_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_op;
  logic [REG_IDX_W-1:0] in_rs1;
  logic [REG_IDX_W-1:0] in_rs2;
  logic [REG_IDX_W-1:0] in_rd;
  logic [XLEN-1:0]      in_imm;
  logic                 in_use_imm;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2,
    output in_rd, in_imm, in_use_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2,
    input  in_rd, in_imm, in_use_imm,
    output in_ready
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Integer register file: 2 async reads, 1 sync write,
// x0 hardwired to zero, synchronous clear.
module regfile_2r1w
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] wa,
  input  logic [XLEN-1:0]      wd,
  input  logic [REG_IDX_W-1:0] ra1,
  input  logic [REG_IDX_W-1:0] ra2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else if (we && wa != '0) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around a combinational ALU.
// Define ALU_OVF_TRAP_EN for the sticky overflow trap.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_stage_if.slave     issue,
  input  logic                 hold,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_op,
  input  logic [XLEN-1:0]      alu_out,
  input  logic [2:0]           alu_status,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data,
  output logic [2:0]           flags,
  output logic                 illegal_op,
  output logic                 trap
);

  logic                 ex_valid;
  logic                 ex_ill;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 accept;
  logic                 retire;
  logic                 ovf;
  logic                 commit;
  logic                 rf_we;
  logic                 fwd1;
  logic                 fwd2;
  logic [XLEN-1:0]      rd1;
  logic [XLEN-1:0]      rd2;
  logic [XLEN-1:0]      opa;
  logic [XLEN-1:0]      opb;

  regfile_2r1w u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (rf_we),
    .wa    (ex_rd),
    .wd    (alu_out),
    .ra1   (issue.in_rs1),
    .ra2   (issue.in_rs2),
    .rd1   (rd1),
    .rd2   (rd2)
  );

`ifdef ALU_OVF_TRAP_EN
  assign ovf = ~ex_ill
             & (alu_op[2:0] == OP_ADD
             |  alu_op[2:0] == OP_SUB)
             & alu_status[ST_V];

  // Once set, nothing further retires or issues.
  always_ff @(posedge clk) begin
    if (reset)
      trap <= 1'b0;
    else if (retire & ovf)
      trap <= 1'b1;
  end
`else
  assign ovf  = 1'b0;
  assign trap = 1'b0;
`endif

  assign issue.in_ready = ~hold & ~trap;
  assign accept = issue.in_valid & issue.in_ready;
  assign retire = ex_valid & ~hold & ~trap;
  assign commit = retire & ~ex_ill & ~ovf;
  assign rf_we  = commit & (ex_rd != '0);

  // rf_we already excludes x0, so no rs!=0 test.
  assign fwd1 = rf_we & (issue.in_rs1 == ex_rd);
  assign fwd2 = rf_we & (issue.in_rs2 == ex_rd);

  assign opa = fwd1 ? alu_out : rd1;
  assign opb = issue.in_use_imm ? issue.in_imm
             : fwd2 ? alu_out : rd2;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_ill     <= 1'b0;
      ex_rd      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      flags      <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (accept) begin
        ex_valid <= 1'b1;
        ex_ill   <= issue.in_op[3];
        ex_rd    <= issue.in_rd;
        alu_a    <= opa;
        alu_b    <= opb;
        alu_op   <= issue.in_op[3] ? 4'd0
                  : issue.in_op;
      end else if (retire) begin
        ex_valid <= 1'b0;
      end
      wb_valid   <= commit;
      illegal_op <= retire & ex_ill;
      if (commit) begin
        wb_rd   <= ex_rd;
        wb_data <= alu_out;
      end
      if (retire & ~ex_ill)
        flags <= alu_status;
    end
  end

endmodule
